conv2_window_gen: RTL and testbench
===================================

Name: conv2_window_gen

Overview:
Streaming sliding-window generator that sits directly upstream of the multi-channel 3x3 convolution stage. Accepts one pixel per beat, each beat carrying all N_IN channels, in raster order. Buffers two previous rows in line buffers and emits a 3x3xN_IN window for every valid (unpadded) output position, in the window[k][ch] layout the conv stage consumes. Provides valid/ready backpressure on both sides; the conv stage ties out_ready high.

Parameters:
N_IN, 16, input channels per pixel
IMG_W, 16, image width in pixels (>=3)
IMG_H, 16, image height in pixels (>=3)
K, 3, kernel size (fixed at 3; other values unsupported)
DATA_W, 8, signed activation width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sync_clear  in  1  synchronous clear of counters/valid; line buffers untouched
in_pix  in  N_IN x DATA_W signed  one pixel, all channels, in_pix[ch]
in_valid  in  1  in_pix valid
in_ready  out  1  beat accepted when in_valid && in_ready
window  out  K*K x N_IN x DATA_W signed  window[k][ch], k = r*3+c, r0 = top (oldest) row, c0 = leftmost column
window_valid  out  1  window holds a valid window
out_ready  in  1  downstream accepts window
out_last  out  1  qualifies window_valid; last window of the frame
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst_n=0, async): col_cnt=0, row_cnt=0, window regs all 0, window_valid=0, out_last=0, frame_done=0. Line buffer storage is not reset.
- in_ready = !window_valid || out_ready (combinational). Stall holds window, window_valid, out_last, and all state.
- On accept at position (row_cnt, col_cnt):
  - top = lb1[col], mid = lb0[col], bot = in_pix.
  - Write lb1[col] <= lb0[col] and lb0[col] <= in_pix.
  - Window shift register shifts one column left; column 2 <= {top, mid, bot}.
- Emission: if row_cnt>=2 and col_cnt>=2 on the accepted beat, window_valid=1 on the next cycle, so latency is 1 cycle after accept. The window spans rows row-2..row and cols col-2..col.
- If the accepted beat does not emit and out_ready is 1, window_valid drops to 0. A window that is not consumed is never overwritten (guaranteed by in_ready).
- Counters:
  - col_cnt wraps IMG_W-1 -> 0 and increments row_cnt.
  - At (IMG_H-1, IMG_W-1), row_cnt wraps to 0 and frame_done pulses next cycle. The next frame's first beat may be accepted in the same cycle.
- Row-start columns (col 0, 1) feed the shift register but never emit, so no cross-row windows are produced. Row wrap needs no flush.
- out_last=1 with the window emitted for position (IMG_H-1, IMG_W-1).
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- sync_clear has priority over an accept in the same cycle: counters=0, window_valid=0, out_last=0, frame_done=0, and no accept (in_ready forced 0 that cycle). Stale line-buffer data is harmless because rows 0-1 never emit.
- Reset mid-frame: all outputs return to reset values immediately, and the next accepted beat is treated as (0,0).
- No arithmetic; data passes bit-exact, sign untouched.

Decomposition:
- Shared package cnn_pkg: DATA_W, N_IN, K localparams; typedef pix_t (DATA_W signed); typedef pix_vec_t (N_IN x pix_t); typedef window_t (K*K x pix_vec_t). The same package is used by conv2_layer's window port.
- Sub-module line_buffer: single-port read-before-write RAM, depth IMG_W, width N_IN*DATA_W, combinational read. Instantiate it twice (lb0, lb1), or once with 2*N_IN*DATA_W width.
- Counters, shift register, and handshake stay in the top module.

Test Plan:
Unless noted, use IMG_W=5, IMG_H=4, N_IN=2, out_ready=1, and in_pix[ch] = r*16 + c + ch*64.
1. Continuous frame, in_valid=1 -> exactly 6 windows.
   - First window one cycle after accepting (2,2): window[0][0]=0, window[4][0]=17, window[8][0]=34, window[8][1]=98.
   - out_last=1 only on the 6th window (window[8][0]=52); frame_done pulses once.
2. Row boundary -> no window emitted after accepting (3,0) or (3,1). The window after (3,2) has window[0][0]=16, window[8][0]=50.
3. Backpressure: out_ready=0 for 4 cycles while the first window is valid -> in_ready=0, window stays stable (window[8][0]=34). Then out_ready=1 -> the stream resumes with no lost or duplicated windows (6 total).
4. Random in_valid gaps (~50%) with random out_ready -> window sequence identical to scenario 1, compared by scoreboard.
5. Reset: rst_n pulsed low after 8 beats -> all outputs 0 asynchronously. A full frame afterwards yields the same 6 windows as scenario 1. Repeat with sync_clear instead of rst_n.
6. Back-to-back frames, second frame value offset +1 -> 12 windows. The first window of frame 2 has window[0][0]=1, and frame_done pulses twice.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN types: one signed activation, one multi-channel pixel and
// one KxK multi-channel window, as exchanged between the window generator and conv2_layer.
package cnn_pkg;

   localparam int DATA_W = 8;
   localparam int N_IN   = 16;
   localparam int K      = 3;
   localparam int KK     = K * K;

   typedef logic signed [DATA_W-1:0] pix_t;
   typedef pix_t [N_IN-1:0]          pix_vec_t;
   typedef pix_vec_t [KK-1:0]        window_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port line buffer: combinational read, read-before-write on the same
// address within a cycle. Storage is deliberately not reset.
module line_buffer #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 256,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv2_window_gen.sv
// Streaming 3x3xN_IN sliding-window generator: two line buffers plus a
// 3-column shift register, valid/ready on both sides, no arithmetic on data.
module conv2_window_gen
   import cnn_pkg::*;
#(
   parameter int N_IN   = cnn_pkg::N_IN,
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int K      = cnn_pkg::K,
   parameter int DATA_W = cnn_pkg::DATA_W
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          sync_clear,
   input  logic signed [N_IN-1:0][DATA_W-1:0]            in_pix,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   output logic signed [K*K-1:0][N_IN-1:0][DATA_W-1:0]   window,
   output logic                                          window_valid,
   input  logic                                          out_ready,
   output logic                                          out_last,
   output logic                                          frame_done
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PIX_W = N_IN * DATA_W;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_EMIT = COL_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(K - 1);

   logic [COL_W-1:0]         col_cnt;
   logic [ROW_W-1:0]         row_cnt;
   logic                     accept;
   logic                     emit;
   logic                     at_frame_end;
   logic [2*PIX_W-1:0]       lb_rdata;
   logic [2*PIX_W-1:0]       lb_wdata;
   logic [PIX_W-1:0]         top_pix;
   logic [PIX_W-1:0]         mid_pix;
   logic [K-1:0][PIX_W-1:0]  new_col;

   // A held window blocks input; sync_clear also blocks so the clear always wins.
   assign in_ready     = !sync_clear && (!window_valid || out_ready);
   assign accept       = in_valid && in_ready;
   assign emit         = (row_cnt >= ROW_EMIT) && (col_cnt >= COL_EMIT);
   assign at_frame_end = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);

   // Both line buffers share one RAM word per column: {lb1, lb0}.
   assign {top_pix, mid_pix} = lb_rdata;
   assign lb_wdata           = {mid_pix, PIX_W'(in_pix)};
   assign new_col            = {PIX_W'(in_pix), mid_pix, top_pix};

   line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (2 * PIX_W),
      .AW    (COL_W)
   ) u_line_buffer (
      .clk   (clk),
      .we    (accept),
      .addr  (col_cnt),
      .wdata (lb_wdata),
      .rdata (lb_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (sync_clear) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (accept) begin
         if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
         end else begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   // Row r of the window lives at k = r*K .. r*K+K-1; newest column enters at the right.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window <= '0;
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
               window[r*K+c] <= window[r*K+c+1];
            end
            window[r*K+K-1] <= new_col[r];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         window_valid <= 1'b0;
         out_last     <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (sync_clear) begin
            window_valid <= 1'b0;
            out_last     <= 1'b0;
         end else if (accept) begin
            window_valid <= emit;
            out_last     <= emit && at_frame_end;
            frame_done   <= at_frame_end;
         end else if (out_ready) begin
            window_valid <= 1'b0;
            out_last     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv2_window_gen.sv
// Bench for conv2_window_gen: image-level window model feeding an expected
// queue, a per-cycle compare process, and directed scenarios with literal pins.
module tb_conv2_window_gen;

   localparam int N_IN   = 2;
   localparam int IMG_W  = 5;
   localparam int IMG_H  = 4;
   localparam int K      = 3;
   localparam int KK     = K * K;
   localparam int DATA_W = 8;
   localparam int WIN_W  = KK * N_IN * DATA_W;

   typedef logic [KK-1:0][N_IN-1:0][DATA_W-1:0] win_t;

   logic clk = 1'b0;
   logic rst_n;
   logic sync_clear;
   logic signed [N_IN-1:0][DATA_W-1:0] in_pix;
   logic in_valid;
   logic in_ready;
   logic signed [KK-1:0][N_IN-1:0][DATA_W-1:0] window;
   logic window_valid;
   logic out_ready;
   logic out_last;
   logic frame_done;

   int n_checks = 0;
   int n_pass   = 0;
   int fd_count = 0;
   bit rand_valid = 1'b0;
   bit rand_ready = 1'b0;

   logic [WIN_W-1:0] exp_q[$];
   logic             exp_last_q[$];
   win_t             got_q[$];
   logic             got_last_q[$];
   logic [WIN_W-1:0] exp_win;
   logic             exp_last;

   conv2_window_gen #(
      .N_IN   (N_IN),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .K      (K),
      .DATA_W (DATA_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sync_clear   (sync_clear),
      .in_pix       (in_pix),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .window       (window),
      .window_valid (window_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .frame_done   (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [WIN_W-1:0] act,
                        input logic [WIN_W-1:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   function automatic logic [DATA_W-1:0] pix_val(input int r, input int c,
                                                 input int ch, input int off);
      return DATA_W'(r * 16 + c + ch * 64 + off);
   endfunction

   // Every fully-interior 3x3 neighbourhood of the image, in raster order.
   function automatic void push_frame(input int off);
      win_t w;
      for (int r = K - 1; r < IMG_H; r++) begin
         for (int c = K - 1; c < IMG_W; c++) begin
            for (int rr = 0; rr < K; rr++)
               for (int cc = 0; cc < K; cc++)
                  for (int ch = 0; ch < N_IN; ch++)
                     w[rr*K+cc][ch] = pix_val(r - 2 + rr, c - 2 + cc, ch, off);
            exp_q.push_back(w);
            exp_last_q.push_back((r == IMG_H - 1) && (c == IMG_W - 1));
         end
      end
   endfunction

   // Compare process: a window is consumed on each edge where valid && ready.
   always @(negedge clk) begin
      if (frame_done) fd_count++;
      if (window_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_window", 1, 0);
         end else begin
            exp_win  = exp_q.pop_front();
            exp_last = exp_last_q.pop_front();
            check("window", window, exp_win);
            check("out_last", out_last, exp_last);
         end
         got_q.push_back(window);
         got_last_q.push_back(out_last);
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic drive_pixel(input int r, input int c, input int off);
      bit accepted;
      int budget;
      bit last_pos;
      bit emit_pos;
      if (rand_valid) begin
         for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
            in_valid = 1'b0;
            cycle();
         end
      end
      in_valid = 1'b1;
      for (int ch = 0; ch < N_IN; ch++) in_pix[ch] = pix_val(r, c, ch, off);
      accepted = 1'b0;
      budget   = 0;
      while (!accepted && budget < 100) begin
         @(negedge clk);
         accepted = in_ready;
         cycle();
         budget++;
      end
      if (!accepted) begin
         check("accept_timeout", 0, 1);
      end else begin
         last_pos = (r == IMG_H - 1) && (c == IMG_W - 1);
         emit_pos = (r >= 2) && (c >= 2);
         check($sformatf("valid_after_%0d_%0d", r, c), window_valid, emit_pos);
         check($sformatf("last_after_%0d_%0d", r, c), out_last, emit_pos && last_pos);
         check($sformatf("done_after_%0d_%0d", r, c), frame_done, last_pos);
      end
   endtask

   task automatic send_range(input int off, input int first, input int last_idx);
      for (int i = first; i <= last_idx; i++) drive_pixel(i / IMG_W, i % IMG_W, off);
   endtask

   task automatic drain();
      in_valid   = 1'b0;
      rand_valid = 1'b0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      repeat (4) cycle();
   endtask

   task automatic start_scenario();
      got_q.delete();
      got_last_q.delete();
      fd_count = 0;
   endtask

   task automatic end_scenario(input string name, input int n_win, input int n_done);
      check({name, "_window_count"}, got_q.size(), n_win);
      check({name, "_frame_done_count"}, fd_count, n_done);
      check({name, "_expected_left"}, exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_window"}, window, '0);
      check({name, "_window_valid"}, window_valid, 0);
      check({name, "_out_last"}, out_last, 0);
      check({name, "_frame_done"}, frame_done, 0);
   endtask

   initial begin
      int n_last;
      rst_n      = 1'b0;
      sync_clear = 1'b0;
      in_valid   = 1'b0;
      in_pix     = '0;
      out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      cycle();

      // Continuous frame with literal pins on the model.
      start_scenario();
      push_frame(0);
      send_range(0, 0, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s1", 6, 1);
      if (got_q.size() == 6) begin
         check("s1_w0_k0", got_q[0][0][0], 0);
         check("s1_w0_k4", got_q[0][4][0], 17);
         check("s1_w0_k8", got_q[0][8][0], 34);
         check("s1_w0_k8_ch1", got_q[0][8][1], 98);
         check("s2_w3_k0", got_q[3][0][0], 16);
         check("s2_w3_k8", got_q[3][8][0], 50);
         check("s1_w5_k8", got_q[5][8][0], 52);
         check("s1_w5_last", got_last_q[5], 1);
         n_last = 0;
         foreach (got_last_q[i]) n_last += int'(got_last_q[i]);
         check("s1_last_count", n_last, 1);
      end

      // Backpressure while the first window is held.
      start_scenario();
      push_frame(0);
      send_range(0, 0, 2 * IMG_W + 2);
      out_ready = 1'b0;
      for (int ch = 0; ch < N_IN; ch++) in_pix[ch] = pix_val(2, 3, ch, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("s3_in_ready_stalled", in_ready, 0);
         check("s3_valid_held", window_valid, 1);
         check("s3_window_held", window[8][0], 34);
         cycle();
      end
      out_ready = 1'b1;
      send_range(0, 2 * IMG_W + 3, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s3", 6, 1);

      // Random input gaps and random downstream ready.
      start_scenario();
      push_frame(0);
      rand_valid = 1'b1;
      rand_ready = 1'b1;
      send_range(0, 0, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s4", 6, 1);

      // Asynchronous reset mid-frame.
      start_scenario();
      send_range(0, 0, 7);
      rst_n = 1'b0;
      #2;
      check_idle_outputs("s5_async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_frame(0);
      send_range(0, 0, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s5_rst", 6, 1);

      // Synchronous clear mid-frame, with a competing input beat.
      start_scenario();
      send_range(0, 0, 7);
      sync_clear = 1'b1;
      in_valid   = 1'b1;
      for (int ch = 0; ch < N_IN; ch++) in_pix[ch] = 8'h7f;
      @(negedge clk);
      check("s5_clear_in_ready", in_ready, 0);
      cycle();
      sync_clear = 1'b0;
      in_valid   = 1'b0;
      check("s5_clear_valid", window_valid, 0);
      check("s5_clear_done", frame_done, 0);
      push_frame(0);
      send_range(0, 0, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s5_clr", 6, 1);

      // Back-to-back frames, second offset by one.
      start_scenario();
      push_frame(0);
      push_frame(1);
      send_range(0, 0, IMG_W * IMG_H - 1);
      send_range(1, 0, IMG_W * IMG_H - 1);
      drain();
      end_scenario("s6", 12, 2);
      if (got_q.size() == 12) check("s6_f2_w0_k0", got_q[6][0][0], 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
